// File: rtl/cnn_frame_scheduler_if.sv
// Purpose: bundles the scheduler's control, camera, engine and result signals.
// Latency: none, wiring only.
// Backpressure: none; the camera and engine are strobe/pulse driven.
//
// Modports:
//   master - the scheduler: samples control/camera/engine inputs, drives
//            cam_req, the engine pixel path and the published result.
//   slave  - the surrounding system: camera, engine and host control.
interface cnn_frame_scheduler_if;
    logic        enable;
    logic        start_now;
    logic        err_clear;
    logic        cam_req;
    logic [7:0]  cam_pixel;
    logic        cam_valid;
    logic [7:0]  cnn_pixel;
    logic        cnn_pixel_valid;
    logic        cnn_frame_start;
    logic        cnn_busy;
    logic        cnn_ready;
    logic        cnn_class;
    logic [7:0]  cnn_conf;
    logic        result_class;
    logic [7:0]  result_conf;
    logic        result_valid;
    logic [1:0]  error_code;
    logic [15:0] frames_done;
    logic [1:0]  sched_state;

    modport master (
        input  enable, start_now, err_clear,
        input  cam_pixel, cam_valid,
        input  cnn_busy, cnn_ready, cnn_class, cnn_conf,
        output cam_req, cnn_pixel, cnn_pixel_valid, cnn_frame_start,
        output result_class, result_conf, result_valid,
        output error_code, frames_done, sched_state
    );

    modport slave (
        output enable, start_now, err_clear,
        output cam_pixel, cam_valid,
        output cnn_busy, cnn_ready, cnn_class, cnn_conf,
        input  cam_req, cnn_pixel, cnn_pixel_valid, cnn_frame_start,
        input  result_class, result_conf, result_valid,
        input  error_code, frames_done, sched_state
    );
endinterface

// File: rtl/cnn_frame_scheduler.sv
// Purpose: triggers camera frames, gates IMG_SIZE pixels into cnn_inference, publishes results.
// Latency: cam pixel -> cnn_pixel 1 cycle; cnn_ready -> result_valid/result fields 1 cycle.
// Backpressure: none; engine busy only defers a launch, stalls are caught by TIMEOUT_CYCLES.
//
// Ports: clk, rst_n (async, active-low) plus interface bus (master modport):
//   enable/start_now/err_clear  host control
//   cam_req, cam_pixel/cam_valid  camera frame request and pixel stream
//   cnn_pixel/cnn_pixel_valid, cnn_frame_start, cnn_busy, cnn_ready, cnn_class, cnn_conf  engine
//   result_class/result_conf/result_valid, error_code, frames_done, sched_state  status
// Optional macro CNN_SCHED_VOTE_EN: result_class becomes the majority of the
// last three classes returned by the engine (history resets to zeros).
module cnn_frame_scheduler #(
    parameter int IMG_SIZE       = 1024,
    parameter int PERIOD_CYCLES  = 1000000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                   clk,
    input logic                   rst_n,
    cnn_frame_scheduler_if.master bus
);
    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int CW = $clog2(IMG_SIZE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] PIX_LAST    = CW'(IMG_SIZE - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   period_q, period_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   pix_q, pix_d;
    logic [TW-1:0]   to_q, to_d;
    logic            cam_req_q, cam_req_d;
    logic            start_q, start_d;
    logic [7:0]      pix_dat_q, pix_dat_d;
    logic            pix_vld_q, pix_vld_d;
    logic            res_class_q, res_class_d;
    logic [7:0]      res_conf_q, res_conf_d;
    logic            res_vld_q, res_vld_d;
    logic [1:0]      err_q, err_d;
    logic [15:0]     frames_q, frames_d;
    logic [1:0]      err_new;
    logic            trig;
    logic            launch;
`ifdef CNN_SCHED_VOTE_EN
    logic [2:0]      hist_q, hist_d;
`endif

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        pending_d   = pending_q;
        pix_d       = pix_q;
        to_d        = to_q;
        cam_req_d   = 1'b0;
        start_d     = 1'b0;
        pix_dat_d   = pix_dat_q;
        pix_vld_d   = 1'b0;
        res_class_d = res_class_q;
        res_conf_d  = res_conf_q;
        res_vld_d   = 1'b0;
        err_d       = err_q;
        frames_d    = frames_q;
        err_new     = 2'b00;
        trig        = 1'b0;
        launch      = 1'b0;
`ifdef CNN_SCHED_VOTE_EN
        hist_d      = hist_q;
`endif

        // Period timer runs only while enabled; a wrap or a manual request
        // raises the one-deep pending trigger.
        if (bus.enable) begin
            trig = bus.start_now;
            if (period_q == PERIOD_LAST) begin
                period_d = '0;
                trig     = 1'b1;
            end else begin
                period_d = period_q + PW'(1);
            end
        end else begin
            period_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q && bus.enable && !bus.cnn_busy) begin
                    launch    = 1'b1;
                    state_d   = ST_STREAM;
                    cam_req_d = 1'b1;
                    start_d   = 1'b1;
                    pix_d     = '0;
                    to_d      = '0;
                end
            end
            ST_STREAM: begin
                if (bus.cam_valid) begin
                    // Leaving STREAM on the last pixel means any surplus
                    // pixels land in WAIT_RES and are never forwarded.
                    to_d      = '0;
                    pix_dat_d = bus.cam_pixel;
                    pix_vld_d = 1'b1;
                    if (pix_q == PIX_LAST) begin
                        state_d = ST_WAIT_RES;
                    end else begin
                        pix_d = pix_q + CW'(1);
                    end
                end else if (to_q == TO_LAST) begin
                    // Abort: a frame-start pulse rewinds the engine's pixel count.
                    err_new = 2'b01;
                    start_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            ST_WAIT_RES: begin
                if (bus.cnn_ready) begin
`ifdef CNN_SCHED_VOTE_EN
                    hist_d      = {hist_q[1:0], bus.cnn_class};
                    res_class_d = (hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) |
                                  (hist_d[1] & hist_d[2]);
`else
                    res_class_d = bus.cnn_class;
`endif
                    res_conf_d  = bus.cnn_conf;
                    res_vld_d   = 1'b1;
                    frames_d    = frames_q + 16'd1;
                    state_d     = ST_IDLE;
                end else if (to_q == TO_LAST) begin
                    err_new = 2'b10;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A trigger in the launch cycle is a fresh request and survives.
        pending_d = bus.enable & (trig | (pending_q & ~launch));

        // A newly detected error beats a simultaneous clear.
        if (err_new != 2'b00) begin
            err_d = err_new;
        end else if (bus.err_clear) begin
            err_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            pending_q   <= 1'b0;
            pix_q       <= '0;
            to_q        <= '0;
            cam_req_q   <= 1'b0;
            start_q     <= 1'b0;
            pix_dat_q   <= 8'd0;
            pix_vld_q   <= 1'b0;
            res_class_q <= 1'b0;
            res_conf_q  <= 8'd0;
            res_vld_q   <= 1'b0;
            err_q       <= 2'b00;
            frames_q    <= 16'd0;
`ifdef CNN_SCHED_VOTE_EN
            hist_q      <= 3'b000;
`endif
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            pending_q   <= pending_d;
            pix_q       <= pix_d;
            to_q        <= to_d;
            cam_req_q   <= cam_req_d;
            start_q     <= start_d;
            pix_dat_q   <= pix_dat_d;
            pix_vld_q   <= pix_vld_d;
            res_class_q <= res_class_d;
            res_conf_q  <= res_conf_d;
            res_vld_q   <= res_vld_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
`ifdef CNN_SCHED_VOTE_EN
            hist_q      <= hist_d;
`endif
        end
    end

    assign bus.cam_req         = cam_req_q;
    assign bus.cnn_pixel       = pix_dat_q;
    assign bus.cnn_pixel_valid = pix_vld_q;
    assign bus.cnn_frame_start = start_q;
    assign bus.result_class    = res_class_q;
    assign bus.result_conf     = res_conf_q;
    assign bus.result_valid    = res_vld_q;
    assign bus.error_code      = err_q;
    assign bus.frames_done     = frames_q;
    assign bus.sched_state     = state_q;
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Purpose: randomized scoreboard bench for cnn_frame_scheduler (camera + engine models).
// Latency: expects pixels one cycle after sampling, results one cycle after cnn_ready.
// Backpressure: none modelled; engine busy is exercised as a launch gate.
module tb_cnn_frame_scheduler;
    localparam int IMG = 64;
    localparam int PER = 2000;
    localparam int TMO = 100;

    typedef struct {
        logic        cls;
        logic [7:0]  conf;
        logic [15:0] fd;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_frame_scheduler_if bus();

    cnn_frame_scheduler #(
        .IMG_SIZE      (IMG),
        .PERIOD_CYCLES (PER),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cnt = 0;
    int fs_cnt = 0;
    int served = 0;
    int aborts = 0;
    int req_cyc[$];
    logic [7:0] pix_q[$];
    res_t res_q[$];
    logic hist[$];
    logic [15:0] fd_exp = 16'd0;
    logic last_cls = 1'b0;
    logic [7:0] last_conf = 8'd0;
    logic [1:0] err_exp = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops expected pixels and results whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cam_req) begin
                req_cnt++;
                req_cyc.push_back(cyc);
            end
            if (bus.cnn_frame_start) fs_cnt++;
            if (bus.cnn_pixel_valid) begin
                check("pixel_with_frame_start", bus.cnn_frame_start, 0);
                if (pix_q.size() == 0) begin
                    check("unexpected_pixel", pix_q.size(), 1);
                end else begin
                    check("pixel_data", bus.cnn_pixel, pix_q.pop_front());
                end
            end
            if (bus.result_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", res_q.size(), 1);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result_class", bus.result_class, r.cls);
                    check("result_conf", bus.result_conf, r.conf);
                    check("frames_done", bus.frames_done, r.fd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int limit, output bit ok, output int when);
        int n;
        n = 0;
        when = -1;
        while (req_cnt == served && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (req_cnt != served);
        if (ok) begin
            served++;
            when = req_cyc.pop_front();
        end
    endtask

    task automatic pulse_start();
        bus.start_now = 1'b1;
        tick();
        bus.start_now = 1'b0;
    endtask

    task automatic send_pixels(input int npix, input bit pstart, input bit drop_en, input bit spurious);
        logic [7:0] d;
        for (int i = 0; i < npix; i++) begin
            d = 8'($urandom);
            bus.cam_pixel = d;
            bus.cam_valid = 1'b1;
            if (i < IMG) pix_q.push_back(d);
            bus.start_now = pstart && (i == 5 || i == 9);
            if (drop_en && i == 10) bus.enable = 1'b0;
            if (spurious && i == 2) begin
                bus.cnn_ready = 1'b1;
                bus.cnn_class = 1'($urandom);
                bus.cnn_conf  = 8'($urandom);
            end
            tick();
            bus.cam_valid = 1'b0;
            bus.start_now = 1'b0;
            bus.cnn_ready = 1'b0;
            if (i != npix - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // Called just after the edge that sampled the last stimulus event.
    task automatic expect_timeout(input logic [1:0] code, input logic abort);
        check("error_held", bus.error_code, err_exp);
        repeat (TMO - 1) tick();
        check("no_timeout_early", bus.error_code, err_exp);
        check("state_before_timeout", bus.sched_state, (code == 2'b01) ? 1 : 2);
        bus.err_clear = 1'($urandom);
        tick();
        bus.err_clear = 1'b0;
        err_exp = code;
        check("timeout_code", bus.error_code, code);
        check("timeout_state_idle", bus.sched_state, 0);
        check("abort_pulse", bus.cnn_frame_start, abort);
        check("frames_done_held", bus.frames_done, fd_exp);
        check("result_class_held", bus.result_class, last_cls);
        check("result_conf_held", bus.result_conf, last_conf);
        if ($urandom_range(0, 1) == 1) begin
            bus.err_clear = 1'b1;
            tick();
            bus.err_clear = 1'b0;
            err_exp = 2'b00;
            check("err_clear", bus.error_code, 0);
        end
    endtask

    // kind: 0 normal, 1 surplus pixels, 2 camera stall, 3 engine never answers
    task automatic serve(input int kind, input bit pstart, input bit drop_en);
        int npix;
        int ones;
        logic c;
        logic [7:0] q;
        res_t r;
        tick();
        case (kind)
            1:       npix = IMG + $urandom_range(1, 6);
            2:       npix = $urandom_range(1, IMG - 1);
            default: npix = IMG;
        endcase
        send_pixels(npix, pstart, drop_en, (kind == 0) && ($urandom_range(0, 1) == 1));
        if (kind == 2) begin
            expect_timeout(2'b01, 1'b1);
            aborts++;
        end else if (kind == 3) begin
            expect_timeout(2'b10, 1'b0);
        end else begin
            repeat ($urandom_range(0, 20)) tick();
            c = 1'($urandom);
            q = 8'($urandom);
            hist.push_back(c);
            void'(hist.pop_front());
`ifdef CNN_SCHED_VOTE_EN
            ones = 0;
            foreach (hist[k]) ones += int'(hist[k]);
            last_cls = (ones >= 2);
`else
            ones = 0;
            last_cls = c;
`endif
            last_conf = q;
            fd_exp = fd_exp + 16'd1;
            r.cls = last_cls;
            r.conf = q;
            r.fd = fd_exp;
            res_q.push_back(r);
            bus.cnn_class = c;
            bus.cnn_conf  = q;
            bus.cnn_ready = 1'b1;
            tick();
            bus.cnn_ready = 1'b0;
            check("result_valid_pulse", bus.result_valid, 1);
            check("idle_after_result", bus.sched_state, 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached after %0d vectors", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int when;
        int c0;
        int r;
        int kind;
        hist = '{1'b0, 1'b0, 1'b0};
        bus.enable = 1'b0;
        bus.start_now = 1'b0;
        bus.err_clear = 1'b0;
        bus.cam_pixel = 8'd0;
        bus.cam_valid = 1'b0;
        bus.cnn_busy = 1'b0;
        bus.cnn_ready = 1'b0;
        bus.cnn_class = 1'b0;
        bus.cnn_conf = 8'd0;

        // Reset state
        repeat (3) tick();
        check("rst_cam_req", bus.cam_req, 0);
        check("rst_cnn_pixel", bus.cnn_pixel, 0);
        check("rst_cnn_pixel_valid", bus.cnn_pixel_valid, 0);
        check("rst_frame_start", bus.cnn_frame_start, 0);
        check("rst_result", {bus.result_valid, bus.result_class, bus.result_conf}, 0);
        check("rst_error_code", bus.error_code, 0);
        check("rst_frames_done", bus.frames_done, 0);
        check("rst_state", bus.sched_state, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Manual trigger while disabled is ignored
        pulse_start();
        repeat (5) tick();
        check("no_req_when_disabled", req_cnt, served);

        // Automatic trigger timing, coalesced manual triggers, enable drop
        bus.enable = 1'b1;
        c0 = cyc;
        wait_req(PER + 10, ok, when);
        check("auto_req_seen", ok, 1);
        check("auto_req_cycle", when, c0 + PER + 1);
        serve(0, 1'b1, 1'b0);
        wait_req(20, ok, when);
        check("coalesced_extra_req", ok, 1);
        serve(0, 1'b0, 1'b0);
        wait_req(PER, ok, when);
        check("second_auto_seen", ok, 1);
        check("second_auto_cycle", when, c0 + 2 * PER + 1);
        serve(0, 1'b0, 1'b1);
        repeat (2 * PER + 50) tick();
        check("no_req_after_disable", req_cnt, served);

        // Busy engine defers the launch
        bus.enable = 1'b1;
        bus.cnn_busy = 1'b1;
        pulse_start();
        repeat (10) tick();
        check("busy_blocks_launch", req_cnt, served);
        bus.cnn_busy = 1'b0;
        wait_req(5, ok, when);
        check("launch_after_busy", ok, 1);
        serve(0, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            if (req_cnt == served) pulse_start();
            wait_req(PER + 10, ok, when);
            check("req_seen", ok, 1);
            if (!ok) break;
            r = $urandom_range(0, 9);
            kind = (r < 4) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3;
            serve(kind, 1'b0, 1'b0);
        end
        bus.enable = 1'b0;
        repeat (2) tick();
        while (req_cnt > served) begin
            wait_req(5, ok, when);
            serve(0, 1'b0, 1'b0);
            repeat (2) tick();
        end
        repeat (3) tick();
        check("pixels_drained", pix_q.size(), 0);
        check("results_drained", res_q.size(), 0);
        check("cam_req_count", req_cnt, served);
        check("frame_start_count", fs_cnt, served + aborts);

        // Reset mid-frame: immediate idle, no abort pulse
        bus.enable = 1'b1;
        pulse_start();
        wait_req(5, ok, when);
        check("final_req_seen", ok, 1);
        tick();
        send_pixels(10, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("midframe_state", bus.sched_state, 1);
        bus.enable = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", bus.sched_state, 0);
        check("rst_mid_frames_done", bus.frames_done, 0);
        check("rst_mid_error_code", bus.error_code, 0);
        check("rst_mid_pixel_valid", bus.cnn_pixel_valid, 0);
        repeat (3) begin
            tick();
            check("rst_mid_no_abort", bus.cnn_frame_start, 0);
        end
        check("pixels_drained_final", pix_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cnn_frame_scheduler.md
Name: cnn_frame_scheduler

Overview:
Sequences camera frames into the cnn_inference engine. It triggers acquisition periodically or on demand, gates exactly IMG_SIZE pixels into the engine, and waits for the engine's ready pulse. It then publishes the classification result, flagging stalled sensors or hung inference with sticky error codes. It sits between the camera capture interface and cnn_inference in the microgreen monitor top level.

Parameters:
IMG_SIZE, 1024, pixels per frame forwarded to the engine
PERIOD_CYCLES, 1000000, clk cycles between automatic triggers (>=2)
TIMEOUT_CYCLES, 4096, max idle cycles between pixels in STREAM, and max cycles waiting for the result in WAIT_RES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
enable  in  1  scheduler enable; low stops the period timer and new triggers
start_now  in  1  single-cycle manual trigger request
err_clear  in  1  clears error_code
cam_req  out  1  one-cycle frame request to camera
cam_pixel  in  8  camera pixel data
cam_valid  in  1  camera pixel strobe
cnn_pixel  out  8  registered pixel to engine
cnn_pixel_valid  out  1  registered pixel strobe to engine
cnn_frame_start  out  1  one-cycle frame start/abort to engine
cnn_busy  in  1  engine busy
cnn_ready  in  1  engine result pulse
cnn_class  in  1  engine classification
cnn_conf  in  8  engine confidence
result_class  out  1  published classification
result_conf  out  8  published confidence
result_valid  out  1  one-cycle pulse when result fields update
error_code  out  2  sticky: 00 none, 01 pixel timeout, 10 result timeout
frames_done  out  16  completed-frame counter, wraps at 65535
sched_state  out  2  IDLE=0, STREAM=1, WAIT_RES=2

Behaviour:
- Reset: all outputs 0; state IDLE; period counter 0; pending flag 0.
- Period counter:
  - Counts 0..PERIOD_CYCLES-1 while enable=1; at wrap it sets pending.
  - start_now=1 with enable=1 sets pending.
  - Pending is one-deep: triggers arriving while pending is set coalesce.
  - enable=0 holds the counter at 0 and clears pending. The current frame completes normally.
- IDLE: when pending=1, enable=1 and cnn_busy=0, the next edge does the following:
  - enters STREAM
  - pulses cam_req and cnn_frame_start for one cycle
  - clears pending
  - zeroes the pixel count and timeout counter
- STREAM:
  - cam_pixel/cam_valid are sampled only in STREAM. They reach cnn_pixel/cnn_pixel_valid one cycle later, so a pixel is never presented in the same cycle as cnn_frame_start.
  - Only the first IMG_SIZE valid pixels are forwarded. Further pixels are dropped (cnn_pixel_valid=0).
  - The edge that accepts pixel IMG_SIZE moves the state to WAIT_RES.
  - The timeout counter clears on each cam_valid. On reaching TIMEOUT_CYCLES: error_code=01, one-cycle cnn_frame_start (abort, resets the engine pixel count), return to IDLE.
- WAIT_RES:
  - The timeout counter restarts on entry.
  - On cnn_ready=1: latch cnn_class/cnn_conf into result_class/result_conf, pulse result_valid on the following cycle, increment frames_done, go to IDLE.
  - On timeout: error_code=10, go to IDLE, results unchanged.
- error_code:
  - Sticky until err_clear=1.
  - A new error in the same cycle as err_clear wins.
  - A later error overwrites an earlier one.
- cnn_ready outside WAIT_RES is ignored.
- Pending set during STREAM/WAIT_RES is serviced on return to IDLE, once cnn_busy=0.
- Reset asserted mid-frame returns to IDLE immediately, with no abort pulse; the engine shares rst_n.

Optional Feature:
CNN_SCHED_VOTE_EN:
- Defined: result_class is the majority of the last three latched cnn_class values. The 3-entry history resets to 0 and shifts on each cnn_ready in WAIT_RES. result_conf is the raw latest value.
- Undefined: result_class is the raw cnn_class.

Test Plan:
- enable=1, start_now pulse, camera sends 1024 pixels, engine returns ready with class=1, conf=0xC8 → one cam_req and one cnn_frame_start; exactly 1024 cnn_pixel_valid; result_valid pulse; result_class=1, result_conf=0xC8, frames_done=1.
- Camera sends 1030 pixels → only 1024 forwarded; the 6 extra produce no cnn_pixel_valid.
- Camera stops after 500 pixels → TIMEOUT_CYCLES later error_code=01, one cnn_frame_start abort pulse, state IDLE; err_clear → 00.
- Full frame sent, cnn_ready never arrives → error_code=10 after TIMEOUT_CYCLES; frames_done unchanged.
- PERIOD_CYCLES=2000, start_now pulsed twice during STREAM → exactly one extra frame follows; automatic frames start every 2000 cycles while enable=1; enable=0 stops triggers.
- With CNN_SCHED_VOTE_EN, classes 1,0,1,0 → result_class 0,0,1,0.
